uart_result_sender: RTL and testbench
=====================================

// Module: uart_result_sender
// PURPOSE
//  Transmit-side counterpart to the UART loader. It buffers the shared secret (SS) that the decap
//  core writes as 64-bit words, then streams one status byte plus the SS bytes to the host over UART 8N1.
//  It sits between the decap core's SS write port and the FPGA tx pin, and is started by the wrapper.
// PARAMETERS
//  SS_BYTES  64          shared-secret length in bytes; must be a multiple of 8
//  CLK_HZ    50_000_000  clk frequency in Hz
//  BIT_RATE  115_200     UART baud; CPB = CLK_HZ/BIT_RATE (truncating integer division)
//  OK_BYTE   8'hA5       status byte sent when status_ok = 1
//  ERR_BYTE  8'hE1       status byte sent when status_ok = 0
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset; asynchronous, active-high
//  tx         out  1                 UART serial out; idles high
//  start      in   1                 1-cycle pulse from the wrapper; begins a transmission
//  status_ok  in   1                 sampled on the start cycle; selects OK_BYTE or ERR_BYTE
//  busy       out  1                 high from the cycle after an accepted start until done
//  done       out  1                 1-cycle pulse once the last stop bit has completed
//  ss_we      in   1                 SS buffer write enable (from decap)
//  ss_addr    in   $clog2(SS_BYTES/8) SS word index
//  ss_wdata   in   64                SS word; little-endian, byte 0 in [7:0]
// BEHAVIOUR
//  Reset values: tx=1, busy=0, done=0, FSM=S_IDLE, byte index=0. The SS buffer has no reset.
//  Buffer: ss_mem[0:SS_BYTES/8-1] x 64.
//   - Written when ss_we && !busy. Writes while busy are dropped.
//   - A write in the same cycle as start is accepted.
//  Stream order: index 0 = status byte; index i = 1..SS_BYTES sends byte b = i-1,
//   taken as ss_mem[b>>3][8*b[2:0] +: 8]. Lane 0 goes first, matching the loader's packing.
//  Frame: start bit (0), data bits D0..D7 LSB first, stop bit (1). Each bit lasts exactly CPB cycles,
//   so one frame is 10*CPB cycles.
//  FSM:
//   - S_IDLE: on start, latch the status byte, set index=0, go to S_LOAD.
//   - S_LOAD: present the byte at index to the transmitter with tx_valid=1; go to S_WAIT on accept
//     (tx_valid && tx_ready).
//   - S_WAIT: when tx_ready returns high, go to S_DONE if index==SS_BYTES; otherwise index+1 and S_LOAD.
//   - S_DONE: done=1 for one cycle, then S_IDLE.
//  Latency and timing:
//   - start on edge k -> tx falls (header start bit) at edge k+2.
//   - Idle-high gap between consecutive frames is at most 2 cycles.
//   - done pulses at most 2 cycles after the final stop bit ends.
//   - busy deasserts in the same cycle done pulses.
//  Boundaries:
//   - start while busy (or in S_DONE) is ignored.
//   - start in the cycle after done starts a new stream normally.
//   - The index counter is wide enough to reach SS_BYTES without wrapping.
//   - rst mid-frame: tx goes high immediately (asynchronous), FSM returns to S_IDLE, the current frame
//     is abandoned, the buffer is kept, and the next start resends from the status byte.
// STRUCTURE
//  Shared package hqc_uart_pkg holds:
//   - FRAME_BITS=10
//   - function cycles_per_bit(clk_hz, bit_rate)
//   - OK/ERR status byte constants
//   - default SS_BYTES
//  Sub-module uart_tx_byte (CLK_HZ, BIT_RATE): ports clk, rst, tx_valid, tx_data[7:0], tx_ready, tx.
//   - tx_ready is high when idle; it drops on the cycle after accept and stays low for 10*CPB cycles.
//   - Contains a baud counter, a bit counter and a shift register.
//  The top level holds the buffer, the byte mux and the FSM.
// TESTING  (bench parameters: CLK_HZ=100_000_000, BIT_RATE=5_000_000 -> CPB=20; bench-side UART rx monitor)
//  1. Hold rst for 5 cycles, then release -> tx=1, busy=0, done=0; no tx edges for 500 cycles.
//  2. Write word w = bytes {8w+7..8w} for w=0..7, then start with status_ok=1
//     -> monitor decodes 65 bytes: A5,00,01,...,3F; every bit lasts 20 cycles; exactly one done pulse.
//  3. Same buffer, start with status_ok=0 -> first decoded byte is E1; payload unchanged.
//  4. During a stream, pulse start and write ss_mem[0]=all-FF
//     -> stream is unchanged, one done pulse only; the next stream shows FF in bytes 0..7.
//  5. Assert rst during payload byte 10 -> tx=1 in the same cycle, busy=0;
//     after release, start -> full 65-byte stream from A5, buffer contents intact.
//  6. Issue start in the cycle after done -> second stream is identical to the first;
//     inter-frame idle gap is at most 2 cycles throughout.

Source files
------------

// File: rtl/hqc_uart_pkg.sv
// Shared constants and helpers for the HQC UART loader/sender pair.
// Frame geometry, status bytes and the baud divisor live here so both directions agree.
package hqc_uart_pkg;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_SS_BYTES = 64;

  localparam logic [7:0] STATUS_OK_BYTE  = 8'hA5;
  localparam logic [7:0] STATUS_ERR_BYTE = 8'hE1;

  typedef logic [7:0] uart_byte_t;

  // Truncating division: the bit period is rounded down to whole clock cycles.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte UART 8N1 transmitter: start bit, D0..D7 LSB first, stop bit, CPB cycles per bit.
// tx is registered one cycle behind the shift register so the first start-bit cycle is full length.
module uart_tx_byte
  import hqc_uart_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  uart_byte_t tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int CPB    = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  active;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;

  // Handshake: a byte is taken on any clock edge where tx_valid && tx_ready;
  // tx_ready then stays low for exactly FRAME_BITS*CPB cycles.
  assign tx_ready = !active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '1;
      tx        <= 1'b1;
    end else begin
      tx <= active ? shift_reg[0] : 1'b1;
      if (!active) begin
        if (tx_valid) begin
          active    <= 1'b1;
          shift_reg <= {1'b1, tx_data, 1'b0};
          baud_cnt  <= '0;
          bit_cnt   <= '0;
        end
      end else if (baud_cnt == BAUD_LAST) begin
        baud_cnt  <= '0;
        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
        if (bit_cnt == BIT_LAST) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_result_sender.sv
// Buffers the shared secret written by the decap core and streams a status byte plus the
// SS bytes (word lane 0 first) to the host over UART once the wrapper pulses start.
module uart_result_sender
  import hqc_uart_pkg::*;
#(
  parameter int         SS_BYTES = DEFAULT_SS_BYTES,
  parameter int         CLK_HZ   = 50_000_000,
  parameter int         BIT_RATE = 115_200,
  parameter logic [7:0] OK_BYTE  = STATUS_OK_BYTE,
  parameter logic [7:0] ERR_BYTE = STATUS_ERR_BYTE,
  localparam int        SS_WORDS = SS_BYTES / 8,
  localparam int        ADDR_W   = (SS_WORDS > 1) ? $clog2(SS_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              tx,
  input  logic              start,
  input  logic              status_ok,
  output logic              busy,
  output logic              done,
  input  logic              ss_we,
  input  logic [ADDR_W-1:0] ss_addr,
  input  logic [63:0]       ss_wdata
);

  localparam int IDX_W = $clog2(SS_BYTES + 1);
  localparam int SEL_W = ADDR_W + 3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SS_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  uart_byte_t       status_byte;
  logic [63:0]      ss_mem [SS_WORDS];

  logic             tx_valid;
  logic             tx_ready;
  uart_byte_t       tx_data;
  logic [SEL_W-1:0] byte_sel;

  assign busy     = (state == S_LOAD) || (state == S_WAIT);
  assign done     = (state == S_DONE);
  assign tx_valid = (state == S_LOAD);

  // The buffer is frozen while a stream is in flight so the host sees one consistent secret.
  always_ff @(posedge clk) begin
    if (ss_we && !busy) begin
      ss_mem[ss_addr] <= ss_wdata;
    end
  end

  // Index 0 is the status byte; index i>0 maps to SS byte i-1.
  always_comb begin
    byte_sel = SEL_W'(idx - 1'b1);
    tx_data  = status_byte;
    if (idx != '0) begin
      tx_data = ss_mem[byte_sel[SEL_W-1:3]][{byte_sel[2:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      status_byte <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            status_byte <= status_ok ? OK_BYTE : ERR_BYTE;
            idx         <= '0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (tx_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_ready) begin
            if (idx == IDX_LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_HZ  (CLK_HZ),
    .BIT_RATE(BIT_RATE)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx)
  );

endmodule

// File: tb/tb_uart_result_sender.sv
// Bench for uart_result_sender: serial rx monitor on tx, byte-array model of the SS buffer,
// expected-stream queue per transmission.
module tb_uart_result_sender;

  localparam int CLK_HZ   = 100_000_000;
  localparam int BIT_RATE = 5_000_000;
  localparam int CPB      = 20;
  localparam int SS_BYTES = 64;
  localparam int N_FRAMES = SS_BYTES + 1;
  localparam int BUDGET   = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        status_ok = 1'b0;
  logic        ss_we = 1'b0;
  logic [2:0]  ss_addr = '0;
  logic [63:0] ss_wdata = '0;
  logic        tx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_result_sender #(
    .SS_BYTES(SS_BYTES),
    .CLK_HZ  (CLK_HZ),
    .BIT_RATE(BIT_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx       (tx),
    .start    (start),
    .status_ok(status_ok),
    .busy     (busy),
    .done     (done),
    .ss_we    (ss_we),
    .ss_addr  (ss_addr),
    .ss_wdata (ss_wdata)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] model_mem [SS_BYTES];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_fall_q[$];
  int         rx_gap_q[$];
  int         rx_end = 0;
  int         rx_bad = 0;
  logic       mon_en = 1'b0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         done_busy_errs = 0;
  int         tx_edges = 0;
  logic       tx_prev = 1'b1;
  int         start_cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : rx_monitor
    logic [7:0] data;
    logic       first;
    logic       bad;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        bad   = 1'b0;
        data  = '0;
        first = 1'b0;
        rx_fall_q.push_back(cyc);
        rx_gap_q.push_back(cyc - rx_end);
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (s == 0) begin
              first = tx;
              if (b >= 1 && b <= 8) data[b-1] = tx;
            end else if (tx !== first) begin
              bad = 1'b1;
            end
          end
          if (b == 0 && first !== 1'b0) bad = 1'b1;
          if (b == 9 && first !== 1'b1) bad = 1'b1;
        end
        rx_q.push_back(data);
        if (bad) rx_bad++;
        rx_end = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy !== 1'b0) done_busy_errs++;
      end
      if (tx !== tx_prev) tx_edges++;
      tx_prev = tx;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [2:0] addr, input logic [63:0] data);
    @(posedge clk); #1;
    ss_we = 1'b1; ss_addr = addr; ss_wdata = data;
    @(posedge clk); #1;
    ss_we = 1'b0;
  endtask

  task automatic model_write(input int addr, input logic [63:0] data);
    for (int i = 0; i < 8; i++) model_mem[addr*8 + i] = data[8*i +: 8];
  endtask

  task automatic pulse_start(input logic ok, input logic we, input logic [2:0] addr,
                             input logic [63:0] data);
    @(posedge clk); #1;
    start = 1'b1; status_ok = ok; ss_we = we; ss_addr = addr; ss_wdata = data;
    @(posedge clk); #1;
    start = 1'b0; ss_we = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic build_exp(input logic ok);
    exp_q.delete();
    exp_q.push_back(ok ? 8'hA5 : 8'hE1);
    for (int b = 0; b < SS_BYTES; b++) exp_q.push_back(model_mem[b]);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rx_fall_q.delete();
    rx_gap_q.delete();
    rx_bad = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < BUDGET);
    check({tag, "_done_seen"}, int'(done), 1);
    #1;
  endtask

  task automatic check_stream(input string tag, input int done_base);
    int maxgap;
    int lat;
    maxgap = 0;
    check({tag, "_frames"}, rx_q.size(), N_FRAMES);
    if (rx_fall_q.size() > 0) check({tag, "_start_to_tx"}, rx_fall_q[0] - start_cyc, 2);
    for (int i = 0; i < rx_q.size() && i < N_FRAMES; i++)
      check($sformatf("%s_byte%0d", tag, i), int'(rx_q[i]), int'(exp_q[i]));
    for (int i = 1; i < rx_gap_q.size(); i++)
      if (rx_gap_q[i] > maxgap) maxgap = rx_gap_q[i];
    check({tag, "_gap_le2"}, int'(maxgap <= 2), 1);
    check({tag, "_bit_width_errs"}, rx_bad, 0);
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    lat = done_cyc - rx_end;
    check({tag, "_done_latency_ok"}, int'(lat >= 0 && lat <= 2), 1);
    check({tag, "_busy_low_at_done"}, done_busy_errs, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    int edges0;
    logic [63:0] w;

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    tx_prev = tx;
    mon_en = 1'b1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (500) @(negedge clk);
    check("idle_tx_edges", tx_edges, 0);

    // Buffer pattern: word w holds bytes 8w..8w+7, lane 0 lowest.
    for (int wi = 0; wi < 8; wi++) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(8*wi + i);
      do_write(3'(wi), w);
      model_write(wi, w);
    end

    // Stream 1: status OK.
    clear_mon();
    base = done_cnt;
    pulse_start(1'b1, 1'b0, 3'd0, 64'd0);
    check("s1_busy_after_start", int'(busy), 1);
    build_exp(1'b1);
    wait_done("s1");
    check_stream("s1", base);

    // Stream 2 starts the cycle after done; start and writes during it must be ignored.
    clear_mon();
    base = done_cnt;
    pulse_start(1'b1, 1'b0, 3'd0, 64'd0);
    check("s2_busy_after_start", int'(busy), 1);
    repeat ($urandom_range(10, 150)) @(posedge clk);
    #1;
    start = 1'b1; status_ok = 1'b0; ss_we = 1'b1; ss_addr = 3'd0; ss_wdata = '1;
    @(posedge clk); #1;
    start = 1'b0; ss_we = 1'b0;
    do_write(3'd7, {$urandom, $urandom});
    wait_done("s2");
    check_stream("s2", base);

    // Stream 3: status ERR, with a same-cycle write of word 0 that must land.
    clear_mon();
    base = done_cnt;
    pulse_start(1'b0, 1'b1, 3'd0, '1);
    model_write(0, '1);
    build_exp(1'b0);
    wait_done("s3");
    check_stream("s3", base);

    // Random idle rewrites.
    repeat (3) begin
      n = $urandom_range(1, 7);
      w = {$urandom, $urandom};
      do_write(3'(n), w);
      model_write(n, w);
    end
    repeat (20) @(posedge clk);

    // Stream 4: reset during payload byte 10.
    clear_mon();
    pulse_start(1'b1, 1'b0, 3'd0, 64'd0);
    n = 0;
    while (rx_fall_q.size() < 12 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("s4_reached_byte10", int'(rx_fall_q.size() >= 12), 1);
    repeat ($urandom_range(5, 180)) @(posedge clk);
    #1;
    check("s4_busy_mid_frame", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("s4_rst_tx_high", int'(tx), 1);
    check("s4_rst_busy_low", int'(busy), 0);
    check("s4_rst_done_low", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(negedge clk);
    edges0 = tx_edges;
    repeat (50) @(negedge clk);
    check("s4_quiet_after_rst", tx_edges - edges0, 0);

    // Stream 5: full resend after reset, buffer intact.
    clear_mon();
    base = done_cnt;
    pulse_start(1'b1, 1'b0, 3'd0, 64'd0);
    build_exp(1'b1);
    wait_done("s5");
    check_stream("s5", base);
    repeat (300) @(negedge clk);
    check("s5_no_extra_done", done_cnt - base, 1);
    check("s5_no_extra_frames", rx_q.size(), N_FRAMES);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
